// File: rtl/gate16_sched.sv
// gate16_sched: two-port round-robin scheduler that time-shares one
// Not16/And16/Or16 datapath. Each opcode is executed as a short fixed
// microsequence of single-gate passes through a temp register.

// 16-bit inverter primitive.
module Not16 (
  input  logic [15:0] in_i,
  output logic [15:0] out_o
);
  assign out_o = ~in_i;
endmodule

// 16-bit AND primitive.
module And16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] out_o
);
  assign out_o = a_i & b_i;
endmodule

// 16-bit OR primitive.
module Or16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] out_o
);
  assign out_o = a_i | b_i;
endmodule

// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrating; req_ready asserted for the granted port
// EXEC    | running one gate pass per cycle, pass_q = current pass
// RESP    | result held on resp_*, waiting for resp_ready
module gate16_sched #(
  parameter int   N_PORTS = 2,
  parameter logic RR_INIT = 1'b1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [N_PORTS-1:0] req_valid_i,
  output logic [N_PORTS-1:0] req_ready_o,
  input  logic [2:0]         req_op0_i,
  input  logic [2:0]         req_op1_i,
  input  logic [15:0]        req_a0_i,
  input  logic [15:0]        req_a1_i,
  input  logic [15:0]        req_b0_i,
  input  logic [15:0]        req_b1_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [15:0]        resp_data_o,
  output logic               resp_id_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
  typedef enum logic [1:0] {G_NOT, G_AND, G_OR} gate_t;

  state_t      state_q;
  logic        last_grant_q;
  logic [2:0]  pass_q;
  logic [15:0] temp_q, scratch_q, opa_q, opb_q;
  logic [2:0]  op_q;
  logic        id_q;
  logic [15:0] resp_data_q;
  logic        resp_id_q, resp_valid_q, busy_q;

  logic        grant_vld, grant_id, accept;
  gate_t       gate_sel;
  logic [15:0] gate_x, gate_y, gate_out;
  logic [15:0] not_out, and_out, or_out;
  logic        wr_scratch, last_pass;

  function automatic logic [2:0] n_passes(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: n_passes = 3'd1;
      3'd3, 3'd4, 3'd7: n_passes = 3'd2;
      3'd5:             n_passes = 3'd4;
      default:          n_passes = 3'd5;
    endcase
  endfunction

  // Round-robin grant: on a tie the port that did not win last time goes.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req_valid_i == 2'b11) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (req_valid_i[1]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end else if (req_valid_i[0]) begin
      grant_vld = 1'b1;
    end
    req_ready_o = 2'b00;
    if (state_q == ST_IDLE && !reset_i && grant_vld)
      req_ready_o = grant_id ? 2'b10 : 2'b01;
    accept = |(req_valid_i & req_ready_o);
  end

  // Microsequence decode: pick the gate and its inputs for this pass.
  // XOR stashes a|b in scratch on pass 0 so temp can carry ~(a&b).
  always_comb begin
    gate_sel   = G_NOT;
    gate_x     = opa_q;
    gate_y     = opb_q;
    wr_scratch = 1'b0;
    case (op_q)
      3'd0: gate_sel = G_NOT;
      3'd1: gate_sel = G_AND;
      3'd2: gate_sel = G_OR;
      3'd3: begin
        if (pass_q == 3'd0) gate_sel = G_AND;
        else begin gate_sel = G_NOT; gate_x = temp_q; end
      end
      3'd4: begin
        if (pass_q == 3'd0) gate_sel = G_OR;
        else begin gate_sel = G_NOT; gate_x = temp_q; end
      end
      3'd5, 3'd6: begin
        case (pass_q)
          3'd0: begin gate_sel = G_OR; wr_scratch = 1'b1; end
          3'd1: gate_sel = G_AND;
          3'd2: begin gate_sel = G_NOT; gate_x = temp_q; end
          3'd3: begin gate_sel = G_AND; gate_x = scratch_q; gate_y = temp_q; end
          default: begin gate_sel = G_NOT; gate_x = temp_q; end
        endcase
      end
      3'd7: begin
        gate_sel = G_NOT;
        if (pass_q != 3'd0) gate_x = temp_q;
      end
    endcase
    last_pass = (pass_q == n_passes(op_q) - 3'd1);
  end

  Not16 u_not (.in_i(gate_x), .out_o(not_out));
  And16 u_and (.a_i(gate_x), .b_i(gate_y), .out_o(and_out));
  Or16  u_or  (.a_i(gate_x), .b_i(gate_y), .out_o(or_out));

  // Output mux of the shared datapath.
  always_comb begin
    case (gate_sel)
      G_AND:   gate_out = and_out;
      G_OR:    gate_out = or_out;
      default: gate_out = not_out;
    endcase
  end

  // Scheduler FSM: accept, sequence passes, hold response until taken.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= RR_INIT;
      pass_q       <= 3'd0;
      temp_q       <= 16'h0000;
      scratch_q    <= 16'h0000;
      opa_q        <= 16'h0000;
      opb_q        <= 16'h0000;
      op_q         <= 3'd0;
      id_q         <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            opa_q        <= grant_id ? req_a1_i  : req_a0_i;
            opb_q        <= grant_id ? req_b1_i  : req_b0_i;
            op_q         <= grant_id ? req_op1_i : req_op0_i;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            pass_q       <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (wr_scratch) scratch_q <= gate_out;
          else            temp_q    <= gate_out;
          if (last_pass) begin
            resp_data_q  <= gate_out;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            pass_q <= pass_q + 3'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign busy_o       = busy_q;

endmodule
